k007232_mc_pcm: RTL and testbench

- Parametrised successor to the dual-channel 8-bit PCM player.
- NCH channels share one sample ROM through a round-robin slot scheduler.
- Each channel has:
  - its own 12-bit pitch prescaler;
  - a start address up to 24 bits;
  - a loop flag;
  - a bit-7 end marker.
- Sits between the sound CPU register bus and the sample ROM. Feeds 7-bit per-channel sample values to external volume/DAC logic.

---
 rtl/k007232_mc_pcm_if.sv | 27 ++
 rtl/k007232_mc_pcm.sv | 154 +++++++++++++++
 tb/tb_k007232_mc_pcm.sv | 242 ++++++++++++++++++++++++
 3 files changed

// File: rtl/k007232_mc_pcm_if.sv
// Register-bus, sample-ROM and audio-output signals of k007232_mc_pcm.
// master = CPU/ROM/DAC side, slave = the PCM player.
interface k007232_mc_pcm_if #(
    parameter int NCH = 4,
    parameter int AW  = 20
);
    logic                       i_CEN;
    logic                       i_WR;
    logic [$clog2(NCH*8)-1:0]   i_ADDR;
    logic [7:0]                 i_DB;
    logic [7:0]                 i_ROM;
    logic [AW-1:0]              o_SA;
    logic [$clog2(NCH)-1:0]     o_SA_CH;
    logic [NCH*7-1:0]           o_SD;
    logic [NCH-1:0]             o_BUSY;
    logic                       o_IRQ;

    modport master (
        output i_CEN, i_WR, i_ADDR, i_DB, i_ROM,
        input  o_SA, o_SA_CH, o_SD, o_BUSY, o_IRQ
    );

    modport slave (
        input  i_CEN, i_WR, i_ADDR, i_DB, i_ROM,
        output o_SA, o_SA_CH, o_SD, o_BUSY, o_IRQ
    );
endinterface

// File: rtl/k007232_mc_pcm.sv
// NCH-channel 8-bit PCM player sharing one sample ROM through round-robin slots.
// Define K007232_MC_IRQ_EN to enable the end-of-sample interrupt (o_IRQ tied low otherwise).
module k007232_mc_pcm #(
    parameter int NCH = 4,
    parameter int AW  = 20,
    parameter int PW  = 12
) (
    input  logic             mclk,
    input  logic             i_RST,
    k007232_mc_pcm_if.slave  bus
);
    localparam int SW = $clog2(NCH);
    localparam int AD = $clog2(NCH*8);

    typedef enum logic [2:0] {
        REG_RLD_LO = 3'd0,
        REG_RLD_HI = 3'd1,
        REG_ST_LO  = 3'd2,
        REG_ST_MID = 3'd3,
        REG_ST_HI  = 3'd4,
        REG_TRIG   = 3'd5,
        REG_LOOP   = 3'd6,
        REG_KOFF   = 3'd7
    } reg_e;

    logic [PW-1:0]  r_reload [NCH];
    logic [PW-1:0]  r_pre    [NCH];
    logic [AW-1:0]  r_start  [NCH];
    logic [AW-1:0]  r_addr   [NCH];
    logic [6:0]     r_sd     [NCH];
    logic [NCH-1:0] r_loop;
    logic [NCH-1:0] r_active;
    logic [SW-1:0]  r_slot;

    logic [SW-1:0]  w_wr_ch;
    reg_e           w_wr_reg;
    logic           w_wr_hit;
    logic [NCH-1:0] w_sel;
    logic [NCH-1:0] w_trig;
    logic [NCH-1:0] w_koff;
    logic [NCH-1:0] w_eos;
    logic           w_marker;

    // Register decode and per-channel end-of-slot qualifier.
    always_comb begin
        w_wr_ch  = bus.i_ADDR[AD-1:3];
        w_wr_reg = reg_e'(bus.i_ADDR[2:0]);
        w_wr_hit = bus.i_WR && (32'(w_wr_ch) < NCH);
        w_marker = bus.i_ROM[7];
        for (int c = 0; c < NCH; c++) begin
            w_sel[c]  = w_wr_hit && (w_wr_ch == SW'(c));
            w_trig[c] = w_sel[c] && (w_wr_reg == REG_TRIG);
            w_koff[c] = w_sel[c] && (w_wr_reg == REG_KOFF);
            w_eos[c]  = bus.i_CEN && r_active[c] && (r_slot == SW'(c));
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge mclk) begin
        if (i_RST) begin
            r_slot <= '0;
        end else if (bus.i_CEN) begin
            r_slot <= (r_slot == SW'(NCH-1)) ? '0 : r_slot + 1'b1;
        end
    end

    always_ff @(posedge mclk) begin
        if (i_RST) begin
            r_loop   <= '0;
            r_active <= '0;
            // NOTE: these arrays are per-channel flops, not RAM, so resetting them is legal and intended.
            for (int c = 0; c < NCH; c++) begin
                r_reload[c] <= '0;
                r_pre[c]    <= '0;
                r_start[c]  <= '0;
                r_addr[c]   <= '0;
                r_sd[c]     <= '0;
            end
        end else begin
            for (int c = 0; c < NCH; c++) begin
                if (w_sel[c]) begin
                    case (w_wr_reg)
                        REG_RLD_LO: r_reload[c][7:0]     <= bus.i_DB;
                        REG_RLD_HI: r_reload[c][PW-1:8]  <= bus.i_DB[PW-9:0];
                        REG_ST_LO:  r_start[c][7:0]      <= bus.i_DB;
                        REG_ST_MID: r_start[c][15:8]     <= bus.i_DB;
                        REG_ST_HI:  r_start[c][AW-1:16]  <= bus.i_DB[AW-17:0];
                        REG_LOOP:   r_loop[c]            <= bus.i_DB[0];
                        default:    ;
                    endcase
                end

                // A trigger or key-off on this channel replaces its slot processing entirely.
                if (w_trig[c]) begin
                    r_active[c] <= 1'b1;
                    r_addr[c]   <= r_start[c];
                    r_pre[c]    <= r_reload[c];
                end else if (w_koff[c]) begin
                    r_active[c] <= 1'b0;
                end else if (w_eos[c]) begin
                    if (w_marker) begin
                        if (r_loop[c]) begin
                            r_addr[c] <= r_start[c];
                            r_pre[c]  <= r_reload[c];
                        end else begin
                            r_active[c] <= 1'b0;
                        end
                    end else begin
                        r_sd[c] <= bus.i_ROM[6:0];
                        if (&r_pre[c]) begin
                            r_pre[c]  <= r_reload[c];
                            r_addr[c] <= r_addr[c] + 1'b1;
                        end else begin
                            r_pre[c]  <= r_pre[c] + 1'b1;
                        end
                    end
                end
            end
        end
    end

`ifdef K007232_MC_IRQ_EN
    logic [NCH-1:0] r_pend;
    logic           r_irq;

    always_ff @(posedge mclk) begin
        if (i_RST) begin
            r_pend <= '0;
            r_irq  <= 1'b0;
        end else begin
            for (int c = 0; c < NCH; c++) begin
                if (w_trig[c] || w_koff[c]) begin
                    r_pend[c] <= 1'b0;
                end else if (w_eos[c] && w_marker && !r_loop[c]) begin
                    r_pend[c] <= 1'b1;
                end
            end
            r_irq <= |r_pend;
        end
    end

    assign bus.o_IRQ = r_irq;
`else
    assign bus.o_IRQ = 1'b0;
`endif

    assign bus.o_SA    = r_addr[r_slot];
    assign bus.o_SA_CH = r_slot;
    assign bus.o_BUSY  = r_active;

    for (genvar g = 0; g < NCH; g++) begin : g_sd
        assign bus.o_SD[g*7 +: 7] = r_sd[g];
    end
endmodule

// File: tb/tb_k007232_mc_pcm.sv
// Directed bench for k007232_mc_pcm (NCH=4, AW=20, PW=12) with a sparse ROM model.
// o_IRQ expectations follow K007232_MC_IRQ_EN when it is defined for the build.
module tb_k007232_mc_pcm;
    localparam int NCH = 4;
    localparam int AW  = 20;
    localparam int PW  = 12;

`ifdef K007232_MC_IRQ_EN
    localparam logic IRQ_ON = 1'b1;
`else
    localparam logic IRQ_ON = 1'b0;
`endif

    logic mclk = 1'b0;
    logic i_RST;
    int   n_tests = 0;
    int   n_fail  = 0;
    int   tb_slot = 0;

    k007232_mc_pcm_if #(.NCH(NCH), .AW(AW)) bus ();

    k007232_mc_pcm #(.NCH(NCH), .AW(AW), .PW(PW)) dut (
        .mclk  (mclk),
        .i_RST (i_RST),
        .bus   (bus.slave)
    );

    always #5 mclk = ~mclk;

    function automatic logic [7:0] rom_f(input logic [AW-1:0] a);
        case (a)
            20'h00100: return 8'h25;
            20'h00101: return 8'h13;
            20'h00200: return 8'h11;
            20'h00201: return 8'h80;
            20'h00300: return 8'h05;
            20'h00301: return 8'h06;
            20'h00302: return 8'h7A;
            20'hFFFFF: return 8'h22;
            default:   return 8'h00;
        endcase
    endfunction

    always_comb bus.i_ROM = rom_f(bus.o_SA);

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge mclk);
        #1;
    endtask

    task automatic wr(input int ch, input int rg, input logic [7:0] d);
        bus.i_WR   = 1'b1;
        bus.i_ADDR = 5'(ch*8 + rg);
        bus.i_DB   = d;
        tick();
        bus.i_WR   = 1'b0;
    endtask

    task automatic slot();
        bus.i_CEN = 1'b1;
        tick();
        bus.i_CEN = 1'b0;
        tb_slot   = (tb_slot + 1) % NCH;
    endtask

    // Register write landing on the same mclk as a slot-ending i_CEN.
    task automatic wr_slot(input int ch, input int rg, input logic [7:0] d);
        bus.i_CEN  = 1'b1;
        bus.i_WR   = 1'b1;
        bus.i_ADDR = 5'(ch*8 + rg);
        bus.i_DB   = d;
        tick();
        bus.i_CEN  = 1'b0;
        bus.i_WR   = 1'b0;
        tb_slot    = (tb_slot + 1) % NCH;
    endtask

    task automatic goto_slot(input int s);
        while (tb_slot != s) slot();
    endtask

    function automatic logic [6:0] sd(input int c);
        return bus.o_SD[c*7 +: 7];
    endfunction

    initial begin
        i_RST      = 1'b1;
        bus.i_CEN  = 1'b0;
        bus.i_WR   = 1'b0;
        bus.i_ADDR = '0;
        bus.i_DB   = '0;
        tick();
        tick();
        check("rst_sa_ch", 32'(bus.o_SA_CH), 32'd0);
        check("rst_sa",    32'(bus.o_SA),    32'h0);
        check("rst_busy",  32'(bus.o_BUSY),  32'h0);
        check("rst_sd",    32'(bus.o_SD),    32'h0);
        check("rst_irq",   32'(bus.o_IRQ),   32'h0);
        i_RST = 1'b0;

        // Idle rotation: slot owner cycles 0..3 twice, nothing plays.
        for (int i = 0; i < 2*NCH; i++) begin
            check($sformatf("idle_sa_ch%0d", i), 32'(bus.o_SA_CH), 32'(i % NCH));
            slot();
        end
        check("idle_busy", 32'(bus.o_BUSY), 32'h0);
        check("idle_sd",   32'(bus.o_SD),   32'h0);

        // Ch0: reload 0xFFF steps one address per round.
        wr(0, 0, 8'hFF); wr(0, 1, 8'h0F);
        wr(0, 2, 8'h00); wr(0, 3, 8'h01); wr(0, 4, 8'h00);
        wr(0, 5, 8'h00);
        check("c0_busy", 32'(bus.o_BUSY), 32'h1);
        check("c0_sa0",  32'(bus.o_SA),   32'h00100);
        slot();
        check("c0_sd0",  32'(sd(0)),      32'h25);
        goto_slot(0);
        check("c0_sa_ch", 32'(bus.o_SA_CH), 32'd0);
        check("c0_sa1",  32'(bus.o_SA),   32'h00101);
        slot();
        check("c0_sd1",  32'(sd(0)),      32'h13);
        goto_slot(0);
        check("c0_sa2",  32'(bus.o_SA),   32'h00102);
        wr(0, 7, 8'h00);
        check("c0_koff_busy", 32'(bus.o_BUSY), 32'h0);
        check("c0_koff_sd",   32'(sd(0)),      32'h13);

        // Ch1: reload 0xFFE, no loop, end marker at 0x201.
        wr(1, 0, 8'hFE); wr(1, 1, 8'h0F); wr(1, 6, 8'h00);
        wr(1, 2, 8'h00); wr(1, 3, 8'h02); wr(1, 4, 8'h00);
        wr(1, 5, 8'h00);
        goto_slot(1);
        check("c1_sa_r0", 32'(bus.o_SA), 32'h00200);
        slot();
        check("c1_sd",    32'(sd(1)),    32'h11);
        goto_slot(1);
        check("c1_sa_r1", 32'(bus.o_SA), 32'h00200);
        slot();
        goto_slot(1);
        check("c1_sa_r2", 32'(bus.o_SA), 32'h00201);
        check("c1_busy_pre", 32'(bus.o_BUSY), 32'h2);
        slot();
        check("c1_busy_end", 32'(bus.o_BUSY), 32'h0);
        check("c1_sd_held",  32'(sd(1)),      32'h11);
        tick();
        check("c1_irq",      32'(bus.o_IRQ),  32'(IRQ_ON));
        wr(1, 7, 8'h00);
        tick();
        check("c1_irq_clr",  32'(bus.o_IRQ),  32'h0);

        // Ch2: same data with loop enabled.
        wr(2, 0, 8'hFE); wr(2, 1, 8'h0F); wr(2, 6, 8'h01);
        wr(2, 2, 8'h00); wr(2, 3, 8'h02); wr(2, 4, 8'h00);
        wr(2, 5, 8'h00);
        goto_slot(2);
        check("c2_sa_r0", 32'(bus.o_SA), 32'h00200);
        slot();
        goto_slot(2);
        slot();
        goto_slot(2);
        check("c2_sa_mk", 32'(bus.o_SA), 32'h00201);
        slot();
        check("c2_busy",  32'(bus.o_BUSY), 32'h4);
        tick();
        check("c2_irq",   32'(bus.o_IRQ),  32'h0);
        goto_slot(2);
        check("c2_sa_loop", 32'(bus.o_SA), 32'h00200);
        check("c2_sd",      32'(sd(2)),    32'h11);
        wr(2, 7, 8'h00);

        // Ch3: reload rewrite while active, then key-off and trigger on slot-3 i_CEN.
        wr(3, 0, 8'hFF); wr(3, 1, 8'h0F); wr(3, 6, 8'h00);
        wr(3, 2, 8'h00); wr(3, 3, 8'h03); wr(3, 4, 8'h00);
        wr(3, 5, 8'h00);
        goto_slot(3);
        check("c3_sa0", 32'(bus.o_SA), 32'h00300);
        slot();
        check("c3_sd0", 32'(sd(3)),    32'h05);
        wr(3, 0, 8'hFE);
        goto_slot(3);
        check("c3_sa1", 32'(bus.o_SA), 32'h00301);
        slot();
        goto_slot(3);
        check("c3_sa2", 32'(bus.o_SA), 32'h00302);
        wr_slot(3, 7, 8'h00);
        check("c3_koff_busy", 32'(bus.o_BUSY), 32'h0);
        check("c3_koff_sd",   32'(sd(3)),      32'h06);
        goto_slot(3);
        check("c3_frozen",    32'(bus.o_SA),   32'h00302);
        wr_slot(3, 5, 8'h00);
        check("c3_trig_busy", 32'(bus.o_BUSY), 32'h8);
        check("c3_trig_sd",   32'(sd(3)),      32'h06);
        goto_slot(3);
        check("c3_trig_sa",   32'(bus.o_SA),   32'h00300);
        // Trigger ch0 during ch3's slot: ch3 must still be processed.
        wr_slot(0, 5, 8'h00);
        check("c3_other_sd",  32'(sd(3)),      32'h05);
        check("c3_other_busy", 32'(bus.o_BUSY), 32'h9);
        goto_slot(3);
        check("c3_newrld_hold", 32'(bus.o_SA), 32'h00300);
        slot();
        goto_slot(3);
        check("c3_newrld_step", 32'(bus.o_SA), 32'h00301);

        // Ch0 address wrap from 2^AW-1 to 0.
        wr(0, 2, 8'hFF); wr(0, 3, 8'hFF); wr(0, 4, 8'h0F);
        wr(0, 5, 8'h00);
        goto_slot(0);
        check("wrap_sa_top", 32'(bus.o_SA), 32'hFFFFF);
        slot();
        check("wrap_sd",     32'(sd(0)),    32'h22);
        goto_slot(0);
        check("wrap_sa_zero", 32'(bus.o_SA), 32'h00000);
        check("wrap_busy",   32'(bus.o_BUSY), 32'h9);

        // Mid-play reset with i_CEN asserted.
        slot();
        i_RST     = 1'b1;
        bus.i_CEN = 1'b1;
        tick();
        check("mrst_busy",  32'(bus.o_BUSY),  32'h0);
        check("mrst_sd",    32'(bus.o_SD),    32'h0);
        check("mrst_sa_ch", 32'(bus.o_SA_CH), 32'd0);
        check("mrst_sa",    32'(bus.o_SA),    32'h0);
        check("mrst_irq",   32'(bus.o_IRQ),   32'h0);
        i_RST     = 1'b0;
        bus.i_CEN = 1'b0;
        tick();
        check("post_rst_sa_ch", 32'(bus.o_SA_CH), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
